fila_param: RTL and testbench

Parametrised synchronous FIFO queue, next generation of the 8-bit, fixed-depth queue in the controller datapath. Width and depth are parameters. Adds full/empty status, overflow/underflow error reporting and defined behaviour for simultaneous enqueue and dequeue. Sits between the input capture logic and the display/consumer logic on the single 10 kHz system clock.

---
 rtl/fila_pkg.sv | 15 +
 rtl/fila_ptr.sv | 31 +++
 rtl/fila_param.sv | 109 ++++++++++
 tb/tb_fila_param.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/fila_pkg.sv
// fila_pkg: shared defaults and pointer helper for the fila_param queue.
package fila_pkg;

  localparam int FILA_DATA_W_DEF = 8;
  localparam int FILA_DEPTH_DEF  = 8;

  // Wrap-around increment by explicit compare, so DEPTH need not be a power of two.
  function automatic logic [31:0] next_ptr(input logic [31:0] ptr, input logic [31:0] depth);
    if (ptr == depth - 32'd1) begin
      return 32'd0;
    end
    return ptr + 32'd1;
  endfunction

endpackage

// File: rtl/fila_ptr.sv
// fila_ptr: wrapping pointer register (0..DEPTH-1) with advance enable and
// asynchronous active-low clear. Used for both head and tail of fila_param.
module fila_ptr
  import fila_pkg::*;
#(
  parameter int DEPTH = FILA_DEPTH_DEF,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk_10KHz,
  input  logic             reset,
  input  logic             adv,
  output logic [PTR_W-1:0] ptr
);

  logic [PTR_W-1:0] ptr_nxt;

  // Next pointer value, wrapping from DEPTH-1 back to 0.
  always_comb begin
    ptr_nxt = PTR_W'(next_ptr(32'(ptr), 32'(DEPTH)));
  end

  // Pointer register; advances only when the owning request is accepted.
  always_ff @(posedge clk_10KHz or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
    end else if (adv) begin
      ptr <= ptr_nxt;
    end
  end

endmodule

// File: rtl/fila_param.sv
// fila_param: parametrised synchronous FIFO with full/empty status and
// overflow/underflow reporting. Single 10 kHz clock, async active-low reset.
// Optional macro FILA_STICKY_ERR_EN: error flags latch until reset instead of
// pulsing for one cycle.
module fila_param
  import fila_pkg::*;
#(
  parameter int DATA_W = FILA_DATA_W_DEF,
  parameter int DEPTH  = FILA_DEPTH_DEF,
  parameter int LEN_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk_10KHz,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              enqueue_in,
  input  logic              dequeue_in,
  output logic [DATA_W-1:0] data_out,
  output logic [LEN_W-1:0]  len_out,
  output logic              full_out,
  output logic              empty_out,
  output logic              overflow_out,
  output logic              underflow_out
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [LEN_W-1:0]  len_q;
  logic              deq_ok;
  logic              enq_ok;
  logic              ovf_ev;
  logic              unf_ev;

  // Accept decisions. A full queue still takes an enqueue when a dequeue frees
  // a slot in the same cycle; an empty queue never bypasses data_in to data_out.
  always_comb begin
    deq_ok = dequeue_in && (len_q != '0);
    enq_ok = enqueue_in && ((len_q != LEN_W'(DEPTH)) || deq_ok);
    ovf_ev = enqueue_in && !enq_ok;
    unf_ev = dequeue_in && !deq_ok;
  end

  fila_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_head (
    .clk_10KHz (clk_10KHz),
    .reset     (reset),
    .adv       (deq_ok),
    .ptr       (head)
  );

  fila_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_tail (
    .clk_10KHz (clk_10KHz),
    .reset     (reset),
    .adv       (enq_ok),
    .ptr       (tail)
  );

  // Storage write; contents are deliberately not reset.
  always_ff @(posedge clk_10KHz) begin
    if (enq_ok) begin
      mem[tail] <= data_in;
    end
  end

  // Occupancy counter; simultaneous accepts leave it unchanged.
  always_ff @(posedge clk_10KHz or negedge reset) begin
    if (!reset) begin
      len_q <= '0;
    end else if (enq_ok && !deq_ok) begin
      len_q <= len_q + LEN_W'(1);
    end else if (deq_ok && !enq_ok) begin
      len_q <= len_q - LEN_W'(1);
    end
  end

  // Registered output word; holds unless a dequeue is accepted.
  always_ff @(posedge clk_10KHz or negedge reset) begin
    if (!reset) begin
      data_out <= '0;
    end else if (deq_ok) begin
      data_out <= mem[head];
    end
  end

  // Error flags: one-cycle pulses, or latched until reset when sticky.
  always_ff @(posedge clk_10KHz or negedge reset) begin
    if (!reset) begin
      overflow_out  <= 1'b0;
      underflow_out <= 1'b0;
    end else begin
`ifdef FILA_STICKY_ERR_EN
      if (ovf_ev) overflow_out  <= 1'b1;
      if (unf_ev) underflow_out <= 1'b1;
`else
      overflow_out  <= ovf_ev;
      underflow_out <= unf_ev;
`endif
    end
  end

  // Status decoded from the len register.
  always_comb begin
    len_out   = len_q;
    full_out  = (len_q == LEN_W'(DEPTH));
    empty_out = (len_q == '0);
  end

endmodule

// File: tb/tb_fila_param.sv
// tb_fila_param: directed bench for fila_param with DATA_W = 8, DEPTH = 4.
module tb_fila_param;

`ifdef FILA_STICKY_ERR_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic       clk_10KHz;
  logic       reset;
  logic [7:0] data_in;
  logic       enqueue_in;
  logic       dequeue_in;
  logic [7:0] data_out;
  logic [2:0] len_out;
  logic       full_out;
  logic       empty_out;
  logic       overflow_out;
  logic       underflow_out;

  int checks;
  int errors;

  logic [7:0] q[$];
  logic [7:0] exp_dout;
  logic       exp_ovf;
  logic       exp_unf;
  int         step_no;

  fila_param #(.DATA_W(8), .DEPTH(4)) dut (
    .clk_10KHz     (clk_10KHz),
    .reset         (reset),
    .data_in       (data_in),
    .enqueue_in    (enqueue_in),
    .dequeue_in    (dequeue_in),
    .data_out      (data_out),
    .len_out       (len_out),
    .full_out      (full_out),
    .empty_out     (empty_out),
    .overflow_out  (overflow_out),
    .underflow_out (underflow_out)
  );

  initial clk_10KHz = 1'b0;
  always #5 clk_10KHz = ~clk_10KHz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    chk($sformatf("len@%0d", step_no), 32'(len_out), 32'(q.size()));
    chk($sformatf("full@%0d", step_no), 32'(full_out), 32'(q.size() == 4));
    chk($sformatf("empty@%0d", step_no), 32'(empty_out), 32'(q.size() == 0));
    chk($sformatf("dout@%0d", step_no), 32'(data_out), 32'(exp_dout));
    chk($sformatf("ovf@%0d", step_no), 32'(overflow_out), 32'(exp_ovf));
    chk($sformatf("unf@%0d", step_no), 32'(underflow_out), 32'(exp_unf));
  endtask

  // One clock of stimulus followed by a check of every output against the model.
  task automatic step(input bit e, input bit d, input logic [7:0] din);
    bit dok, eok;
    enqueue_in = e;
    dequeue_in = d;
    data_in    = din;
    @(posedge clk_10KHz);
    #1;
    dok = d && (q.size() > 0);
    eok = e && ((q.size() < 4) || dok);
    if (dok) exp_dout = q.pop_front();
    if (eok) q.push_back(din);
    if (STICKY) begin
      exp_ovf = exp_ovf | (e && !eok);
      exp_unf = exp_unf | (d && !dok);
    end else begin
      exp_ovf = e && !eok;
      exp_unf = d && !dok;
    end
    enqueue_in = 1'b0;
    dequeue_in = 1'b0;
    step_no++;
    chk_all();
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    step_no    = 0;
    exp_dout   = 8'h00;
    exp_ovf    = 1'b0;
    exp_unf    = 1'b0;
    reset      = 1'b0;
    data_in    = 8'h00;
    enqueue_in = 1'b0;
    dequeue_in = 1'b0;

    // Reset state
    repeat (2) @(posedge clk_10KHz);
    #1;
    chk_all();
    reset = 1'b1;

    // Enqueue A1, B2, C3
    step(1, 0, 8'hA1);
    step(1, 0, 8'hB2);
    step(1, 0, 8'hC3);
    chk("len3", 32'(len_out), 32'd3);

    // Dequeue twice
    step(0, 1, 8'h00);
    chk("deq_a1", 32'(data_out), 32'hA1);
    step(0, 1, 8'h00);
    chk("deq_b2", 32'(data_out), 32'hB2);
    chk("len1", 32'(len_out), 32'd1);

    // Fill, then overflow with 55
    step(1, 0, 8'hD4);
    step(1, 0, 8'hE5);
    step(1, 0, 8'hF6);
    chk("full4", 32'(full_out), 32'd1);
    step(1, 0, 8'h55);
    chk("ovf_set", 32'(overflow_out), 32'd1);
    step(0, 0, 8'h00);
    chk("ovf_after", 32'(overflow_out), 32'(STICKY));

    // Drain: order C3 D4 E5 F6, 55 never appears
    step(0, 1, 8'h00);
    chk("deq_c3", 32'(data_out), 32'hC3);
    step(0, 1, 8'h00);
    step(0, 1, 8'h00);
    step(0, 1, 8'h00);
    chk("deq_f6", 32'(data_out), 32'hF6);

    // Underflow on empty: data_out holds F6
    step(0, 1, 8'h00);
    chk("unf_set", 32'(underflow_out), 32'd1);
    chk("unf_hold", 32'(data_out), 32'hF6);

    // Fill, then 10 simultaneous cycles through wrap-around while full
    step(1, 0, 8'h10);
    step(1, 0, 8'h11);
    step(1, 0, 8'h12);
    step(1, 0, 8'h13);
    for (int i = 0; i < 10; i++) begin
      step(1, 1, 8'h20 + 8'(i));
      chk($sformatf("sim_len%0d", i), 32'(len_out), 32'd4);
    end
    chk("sim_last", 32'(data_out), 32'h25);

    // Drain, then both requests on empty
    step(0, 1, 8'h00);
    step(0, 1, 8'h00);
    step(0, 1, 8'h00);
    step(0, 1, 8'h00);
    chk("deq_29", 32'(data_out), 32'h29);
    step(1, 1, 8'h77);
    chk("both_empty_len", 32'(len_out), 32'd1);
    chk("both_empty_unf", 32'(underflow_out), 32'd1);
    chk("both_empty_dout", 32'(data_out), 32'h29);

    // Build 3 entries, then async reset mid-cycle
    step(1, 0, 8'h88);
    step(1, 0, 8'h99);
    chk("pre_rst_len", 32'(len_out), 32'd3);
    #2;
    reset = 1'b0;
    #1;
    q.delete();
    exp_dout = 8'h00;
    exp_ovf  = 1'b0;
    exp_unf  = 1'b0;
    step_no++;
    chk_all();
    @(posedge clk_10KHz);
    #1;
    reset = 1'b1;

    // Post-reset operation
    step(1, 0, 8'h5A);
    step(0, 1, 8'h00);
    chk("post_rst", 32'(data_out), 32'h5A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
